// File: rtl/pong_score_ctrl_if.sv
// Signal bundle between the pong graphics/physics block and the score controller.
interface pong_score_ctrl_if;
    logic       tick;
    logic       start;
    logic       miss_1;
    logic       miss_2;
    logic       ball_hold;
    logic [7:0] score_1;
    logic [7:0] score_2;
    logic       point_pulse;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output tick, start, miss_1, miss_2,
        input  ball_hold, score_1, score_2, point_pulse, game_over, winner
    );

    modport slave (
        input  tick, start, miss_1, miss_2,
        output ball_hold, score_1, score_2, point_pulse, game_over, winner
    );
endinterface

// File: rtl/pong_score_ctrl.sv
// Pong game-state and BCD scoring controller: idle -> serve delay -> play -> point -> game over.
module pong_score_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 120
) (
    input  logic              clk,
    input  logic              reset,
    pong_score_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

    localparam logic [7:0] WIN_BCD    = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_TICKS - 1);

    state_t     state_q, state_d;
    logic       start_q;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] score_1_q, score_1_d;
    logic [7:0] score_2_q, score_2_d;
    logic       hold_q, hold_d;
    logic       pp_q, pp_d;
    logic       over_q, over_d;
    logic [1:0] winner_q, winner_d;
    logic       start_rise;
    logic [7:0] bumped;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign start_rise = bus.start & ~start_q;

    // State and all outputs are held in flops; start_q powers up high so a held button is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            start_q   <= 1'b1;
            cnt_q     <= '0;
            score_1_q <= '0;
            score_2_q <= '0;
            hold_q    <= 1'b1;
            pp_q      <= 1'b0;
            over_q    <= 1'b0;
            winner_q  <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= bus.start;
            cnt_q     <= cnt_d;
            score_1_q <= score_1_d;
            score_2_q <= score_2_d;
            hold_q    <= hold_d;
            pp_q      <= pp_d;
            over_q    <= over_d;
            winner_q  <= winner_d;
        end
    end

    // Next-state and next-output logic; misses count only in PLAY, which is left on the scoring edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        score_1_d = score_1_q;
        score_2_d = score_2_q;
        hold_d    = hold_q;
        pp_d      = 1'b0;
        over_d    = over_q;
        winner_d  = winner_q;
        bumped    = '0;

        case (state_q)
            IDLE: begin
                hold_d = 1'b1;
                over_d = 1'b0;
                if (start_rise) begin
                    score_1_d = '0;
                    score_2_d = '0;
                    winner_d  = '0;
                    cnt_d     = '0;
                    state_d   = SERVE;
                end
            end
            SERVE: begin
                hold_d = 1'b1;
                if (bus.tick) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == SERVE_LAST) begin
                        hold_d  = 1'b0;
                        state_d = PLAY;
                    end
                end
            end
            PLAY: begin
                hold_d = 1'b0;
                if (bus.miss_1 || bus.miss_2) begin
                    pp_d   = 1'b1;
                    hold_d = 1'b1;
                    cnt_d  = '0;
                    if (bus.miss_1) begin
                        bumped    = bcd_inc(score_1_q);
                        score_1_d = bumped;
                    end else begin
                        bumped    = bcd_inc(score_2_q);
                        score_2_d = bumped;
                    end
                    if (bumped == WIN_BCD) begin
                        winner_d = bus.miss_1 ? 2'b01 : 2'b10;
                        over_d   = 1'b1;
                        state_d  = OVER;
                    end else begin
                        state_d = SERVE;
                    end
                end
            end
            OVER: begin
                hold_d = 1'b1;
                over_d = 1'b1;
                if (start_rise) begin
                    score_1_d = '0;
                    score_2_d = '0;
                    winner_d  = '0;
                    cnt_d     = '0;
                    over_d    = 1'b0;
                    state_d   = SERVE;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = 1'b1;
                over_d  = 1'b0;
            end
        endcase
    end

    assign bus.ball_hold   = hold_q;
    assign bus.score_1     = score_1_q;
    assign bus.score_2     = score_2_q;
    assign bus.point_pulse = pp_q;
    assign bus.game_over   = over_q;
    assign bus.winner      = winner_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Directed bench: instance A uses default parameters, instance B uses WIN_SCORE=15, SERVE_TICKS=2.
module tb_pong_score_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   pulses;

    pong_score_ctrl_if ifa();
    pong_score_ctrl_if ifb();

    pong_score_ctrl dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    pong_score_ctrl #(.WIN_SCORE(15), .SERVE_TICKS(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int sel, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) ifa.tick = 1'b1; else ifb.tick = 1'b1;
            step();
            if (sel == 0) ifa.tick = 1'b0; else ifb.tick = 1'b0;
            repeat (gap - 1) step();
        end
    endtask

    // Player point on instance A followed by a full 120-tick serve.
    task automatic point_a(input int who);
        if (who == 1) ifa.miss_1 = 1'b1; else ifa.miss_2 = 1'b1;
        step();
        ifa.miss_1 = 1'b0;
        ifa.miss_2 = 1'b0;
        ticks(0, 120, 2);
    endtask

    initial begin
        reset = 1'b1;
        ifa.tick = 1'b0; ifa.start = 1'b0; ifa.miss_1 = 1'b0; ifa.miss_2 = 1'b0;
        ifb.tick = 1'b0; ifb.start = 1'b0; ifb.miss_1 = 1'b0; ifb.miss_2 = 1'b0;
        step();
        step();
        chk("rst_hold", {7'd0, ifa.ball_hold}, 8'h01);
        chk("rst_s1", ifa.score_1, 8'h00);
        chk("rst_s2", ifa.score_2, 8'h00);
        chk("rst_over", {7'd0, ifa.game_over}, 8'h00);
        chk("rst_pp", {7'd0, ifa.point_pulse}, 8'h00);
        chk("rst_win", {6'd0, ifa.winner}, 8'h00);
        reset = 1'b0;
        step();

        // Serve delay: 120 ticks 10 clks apart.
        ifa.start = 1'b1; step(); ifa.start = 1'b0;
        chk("serve_entry_hold", {7'd0, ifa.ball_hold}, 8'h01);
        ticks(0, 119, 10);
        chk("serve_119_hold", {7'd0, ifa.ball_hold}, 8'h01);
        ticks(0, 1, 10);
        chk("serve_120_hold", {7'd0, ifa.ball_hold}, 8'h00);
        ticks(0, 5, 3);
        chk("play_extra_ticks_hold", {7'd0, ifa.ball_hold}, 8'h00);
        chk("play_extra_ticks_s1", ifa.score_1, 8'h00);

        // miss_2 held 5 clks: one point only.
        ifa.miss_2 = 1'b1;
        step();
        chk("m2_s2", ifa.score_2, 8'h01);
        chk("m2_s1", ifa.score_1, 8'h00);
        chk("m2_pp", {7'd0, ifa.point_pulse}, 8'h01);
        chk("m2_hold", {7'd0, ifa.ball_hold}, 8'h01);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ifa.point_pulse === 1'b1) pulses++;
        end
        ifa.miss_2 = 1'b0;
        chk("m2_extra_pulses", 8'(pulses), 8'h00);
        ticks(0, 120, 2);
        chk("m2_after_serve_hold", {7'd0, ifa.ball_hold}, 8'h00);
        chk("m2_after_serve_s2", ifa.score_2, 8'h01);

        // Simultaneous misses: player 1 wins priority; miss_1 in SERVE ignored.
        ifa.miss_1 = 1'b1; ifa.miss_2 = 1'b1;
        step();
        ifa.miss_2 = 1'b0;
        chk("both_s1", ifa.score_1, 8'h01);
        chk("both_s2", ifa.score_2, 8'h01);
        ticks(0, 60, 2);
        chk("serve_miss1_s1", ifa.score_1, 8'h01);
        chk("serve_miss1_hold", {7'd0, ifa.ball_hold}, 8'h01);
        ifa.miss_1 = 1'b0;
        ticks(0, 60, 2);
        chk("serve_done_hold", {7'd0, ifa.ball_hold}, 8'h00);

        // Reach 03/02 in PLAY, then reset mid-rally with start held.
        point_a(1);
        point_a(1);
        point_a(2);
        chk("pre_rst_s1", ifa.score_1, 8'h03);
        chk("pre_rst_s2", ifa.score_2, 8'h02);
        chk("pre_rst_hold", {7'd0, ifa.ball_hold}, 8'h00);
        ifa.start = 1'b1;
        reset = 1'b1;
        #1;
        chk("async_rst_s1", ifa.score_1, 8'h00);
        chk("async_rst_s2", ifa.score_2, 8'h00);
        chk("async_rst_hold", {7'd0, ifa.ball_hold}, 8'h01);
        chk("async_rst_pp", {7'd0, ifa.point_pulse}, 8'h00);
        step();
        #2;
        reset = 1'b0;
        ticks(0, 130, 2);
        chk("idle_held_start_hold", {7'd0, ifa.ball_hold}, 8'h01);
        chk("idle_held_start_s1", ifa.score_1, 8'h00);

        // Default game: player 2 reaches 7.
        ifa.start = 1'b0; step();
        ifa.start = 1'b1; step(); ifa.start = 1'b0;
        ticks(0, 120, 2);
        for (int p = 1; p <= 7; p++) begin
            ifa.miss_2 = 1'b1; step(); ifa.miss_2 = 1'b0;
            if (p == 6) begin
                chk("p2_6_s2", ifa.score_2, 8'h06);
                chk("p2_6_win", {6'd0, ifa.winner}, 8'h00);
                chk("p2_6_over", {7'd0, ifa.game_over}, 8'h00);
            end
            if (p < 7) ticks(0, 120, 2);
        end
        chk("p2_win_s2", ifa.score_2, 8'h07);
        chk("p2_win_winner", {6'd0, ifa.winner}, 8'h02);
        chk("p2_win_over", {7'd0, ifa.game_over}, 8'h01);
        chk("p2_win_hold", {7'd0, ifa.ball_hold}, 8'h01);
        chk("p2_win_pp", {7'd0, ifa.point_pulse}, 8'h01);
        ifa.miss_1 = 1'b1; step(); ifa.miss_1 = 1'b0;
        chk("over_miss1_pp", {7'd0, ifa.point_pulse}, 8'h00);
        ifa.miss_2 = 1'b1; step(); ifa.miss_2 = 1'b0;
        ticks(0, 5, 2);
        chk("over_miss_s1", ifa.score_1, 8'h00);
        chk("over_miss_s2", ifa.score_2, 8'h07);
        chk("over_miss_over", {7'd0, ifa.game_over}, 8'h01);
        ifa.start = 1'b1; step(); ifa.start = 1'b0;
        chk("restart_s1", ifa.score_1, 8'h00);
        chk("restart_s2", ifa.score_2, 8'h00);
        chk("restart_winner", {6'd0, ifa.winner}, 8'h00);
        chk("restart_over", {7'd0, ifa.game_over}, 8'h00);
        chk("restart_hold", {7'd0, ifa.ball_hold}, 8'h01);
        ticks(0, 120, 2);
        chk("restart_serve_done", {7'd0, ifa.ball_hold}, 8'h00);

        // Instance B: WIN_SCORE=15, BCD carry and win at 15.
        ifb.start = 1'b1; step(); ifb.start = 1'b0;
        ticks(1, 2, 2);
        chk("b_play_hold", {7'd0, ifb.ball_hold}, 8'h00);
        for (int p = 1; p <= 15; p++) begin
            ifb.miss_1 = 1'b1; step(); ifb.miss_1 = 1'b0;
            if (p == 9)  chk("b_s1_09", ifb.score_1, 8'h09);
            if (p == 10) chk("b_s1_10", ifb.score_1, 8'h10);
            if (p == 14) begin
                chk("b_s1_14", ifb.score_1, 8'h14);
                chk("b_14_over", {7'd0, ifb.game_over}, 8'h00);
            end
            if (p < 15) ticks(1, 2, 2);
        end
        chk("b_win_s1", ifb.score_1, 8'h15);
        chk("b_win_s2", ifb.score_2, 8'h00);
        chk("b_win_winner", {6'd0, ifb.winner}, 8'h01);
        chk("b_win_over", {7'd0, ifb.game_over}, 8'h01);
        chk("b_win_hold", {7'd0, ifb.ball_hold}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_score_ctrl.md
Name: pong_score_ctrl

Overview:
- Game-state and scoring controller directly downstream of the pong graphics/physics block.
- Consumes that block's miss_1/miss_2 point pulses and keeps each player's score in BCD.
- Drives ball_hold, which connects to the graphics block's game input; while high, the ball is held at screen centre.
- Sequences idle → serve delay → play → point → game over. Score outputs feed the on-screen score text stage.

Parameters:
- WIN_SCORE, 7: score that ends the game. Range 1..99, decimal.
- SERVE_TICKS, 120: frame ticks ball_hold stays high before each serve (2 s at 60 Hz). Range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- tick  in  1  one-clk pulse per frame (60 Hz refresh tick, start of vertical retrace).
- start  in  1  start/restart button, level, already synchronised and debounced.
- miss_1  in  1  player 1 scores. May stay high for several clks.
- miss_2  in  1  player 2 scores. May stay high for several clks.
- ball_hold  out  1  high = ball frozen at centre with serve velocity loaded. Registered.
- score_1  out  8  player 1 score, BCD: [7:4] tens, [3:0] ones.
- score_2  out  8  player 2 score, BCD: [7:4] tens, [3:0] ones.
- point_pulse  out  1  one-clk pulse when a point is awarded (sound/flash hook).
- game_over  out  1  high while in OVER.
- winner  out  2  00 none, 01 player 1, 10 player 2. Held until a new game starts.

Behaviour:
- Reset values (async, immediate):
  - state = IDLE, ball_hold = 1, score_1 = score_2 = 8'h00, point_pulse = 0, game_over = 0, winner = 00, serve counter = 0.
  - Internal start_q resets to 1, so a start held high through reset does not fire an edge.
- start_rise = start & ~start_q; start_q updates every clk.
- States (all outputs registered, updated on the clk edge of the transition):
  - IDLE: ball_hold = 1. On start_rise: clear both scores, clear winner, serve counter = 0, go to SERVE.
  - SERVE: ball_hold = 1.
    - Each tick increments the 8-bit serve counter.
    - On the tick when counter == SERVE_TICKS-1, go to PLAY. SERVE therefore lasts exactly SERVE_TICKS ticks.
    - miss_1/miss_2 and start are ignored.
  - PLAY: ball_hold = 0.
    - miss_1 = 1: increment score_1.
    - Otherwise, miss_2 = 1: increment score_2. If both are high, miss_1 has priority and only player 1 scores.
    - On a scoring clk: point_pulse = 1 for that clk, ball_hold = 1 on the same edge, serve counter = 0.
    - If the new score equals WIN_SCORE, go to OVER and set winner; otherwise go to SERVE.
    - start is ignored.
  - OVER: ball_hold = 1, game_over = 1. On start_rise: clear scores, winner = 00, counter = 0, game_over = 0, go to SERVE.
- One point per rally:
  - Misses are sampled only in PLAY, and PLAY is left on the scoring edge.
  - A miss level persisting into SERVE is never counted again.
- BCD increment: ones 9 → 0 with tens +1. The win check compares the incremented value against WIN_SCORE converted to BCD, so no score exceeds WIN_SCORE.
- Latency: miss sampled at edge N → score, point_pulse, ball_hold valid after edge N.
- tick arriving on the same clk as the SERVE entry edge is not counted.
- Reset mid-operation: all state is lost and the block returns to IDLE with reset values.

Test Plan:
- Reset asserted mid-PLAY with scores 03/02 → all outputs at reset values immediately; hold start high across the reset release → block stays in IDLE.
- Pulse start, then apply 120 ticks spaced 10 clks apart → ball_hold stays 1 through tick 119 and drops after tick 120; extra ticks in PLAY cause no change.
- In PLAY, hold miss_2 high for 5 clks → score_2 = 8'h01, score_1 = 8'h00, exactly one point_pulse, ball_hold = 1 on the same edge; after 120 more ticks ball_hold = 0 and score_2 is still 8'h01.
- In PLAY, raise miss_1 and miss_2 on the same clk → score_1 +1, score_2 unchanged. Raise miss_1 during SERVE → no change.
- WIN_SCORE = 15: player 1 scores 10 points → score_1 goes 8'h09 → 8'h10; on the 15th point → state OVER, score_1 = 8'h15, winner = 01, game_over = 1, ball_hold = 1.
- Default parameters: player 2 reaches 7 → winner = 10. Further miss pulses → no change. start rise → scores 00/00, winner = 00, game_over = 0, block in SERVE.
